// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: data width,
// loader state encodings and the saturating cycle-counter helper.
package prog_loader_pkg;

   // Program word width, matching the core's instruction width.
   localparam int LD_WORD = 32;

   // Loader states.
   typedef enum logic [2:0] {
      LD_LOAD    = 3'd0,
      LD_RELEASE = 3'd1,
      LD_RUN     = 3'd2,
      LD_HALT    = 3'd3,
      LD_ERROR   = 3'd4
   } ld_state_e;

   // Increment that sticks at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader and run controller. Streams program words
// into instruction memory while holding the core in reset, releases the
// core a fixed number of cycles after the final write, then counts run
// cycles until write-back signals terminate.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int WORD        = LD_WORD,
   parameter int DEPTH       = 512,
   parameter int ADDR_W      = $clog2(DEPTH),
   // Must be at least 1.
   parameter int RELEASE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WORD-1:0]   in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD-1:0]   imem_wdata,
   output logic              cpu_rst,
   input  logic              terminate_wb,
   input  logic              reload,
   output logic              halted,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count,
   output logic [31:0]       cycle_count
);

   localparam int REL_W = $clog2(RELEASE_CYC + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   ld_state_e         state_q,       state_d;
   logic              cpu_rst_q,     cpu_rst_d;
   logic              imem_we_q,     imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q,   imem_addr_d;
   logic [WORD-1:0]   imem_wdata_q,  imem_wdata_d;
   logic [ADDR_W:0]   word_count_q,  word_count_d;
   logic [31:0]       cycle_count_q, cycle_count_d;
   logic              halted_q,      halted_d;
   logic              overflow_q,    overflow_d;
   logic [REL_W-1:0]  rel_cnt_q,     rel_cnt_d;

   logic              accept;

   // The loader only takes words while loading; decoded from state alone.
   assign in_ready = (state_q == LD_LOAD);
   assign accept   = in_valid & in_ready;

   assign imem_we     = imem_we_q;
   assign imem_addr   = imem_addr_q;
   assign imem_wdata  = imem_wdata_q;
   assign cpu_rst     = cpu_rst_q;
   assign halted      = halted_q;
   assign overflow    = overflow_q;
   assign word_count  = word_count_q;
   assign cycle_count = cycle_count_q;

   // Next-state and next-output decode for the load/release/run sequence.
   always_comb begin
      state_d       = state_q;
      cpu_rst_d     = cpu_rst_q;
      imem_we_d     = 1'b0;
      imem_addr_d   = imem_addr_q;
      imem_wdata_d  = imem_wdata_q;
      word_count_d  = word_count_q;
      cycle_count_d = cycle_count_q;
      halted_d      = halted_q;
      overflow_d    = overflow_q;
      rel_cnt_d     = rel_cnt_q;

      case (state_q)
         LD_LOAD: begin
            cpu_rst_d = 1'b1;
            if (accept) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = word_count_q[ADDR_W-1:0];
               imem_wdata_d = in_data;
               word_count_d = word_count_q + (ADDR_W+1)'(1);
               if (in_last) begin
                  // A last word landing on the final address is still a legal program.
                  state_d   = LD_RELEASE;
                  rel_cnt_d = REL_W'(RELEASE_CYC);
               end else if (word_count_q[ADDR_W-1:0] == LAST_ADDR) begin
                  state_d    = LD_ERROR;
                  overflow_d = 1'b1;
               end
            end
         end

         LD_RELEASE: begin
            // Counter is loaded with RELEASE_CYC so the final write and the
            // hold cycles both complete before the core leaves reset.
            if (rel_cnt_q == '0) begin
               state_d   = LD_RUN;
               cpu_rst_d = 1'b0;
            end else begin
               rel_cnt_d = rel_cnt_q - REL_W'(1);
            end
         end

         LD_RUN: begin
            cpu_rst_d = 1'b0;
            if (terminate_wb) begin
               state_d  = LD_HALT;
               halted_d = 1'b1;
            end else begin
               cycle_count_d = sat_inc32(cycle_count_q);
            end
         end

         LD_HALT, LD_ERROR: begin
            // The core stays out of reset after a halt so data memory can
            // be inspected; after an overflow it never ran at all.
            cpu_rst_d = (state_q == LD_ERROR);
            if (reload) begin
               state_d       = LD_LOAD;
               cpu_rst_d     = 1'b1;
               imem_addr_d   = '0;
               word_count_d  = '0;
               cycle_count_d = '0;
               halted_d      = 1'b0;
               overflow_d    = 1'b0;
            end
         end

         default: begin
            state_d   = LD_LOAD;
            cpu_rst_d = 1'b1;
         end
      endcase
   end

   // State and registered outputs; reset returns to an empty load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= LD_LOAD;
         cpu_rst_q     <= 1'b1;
         imem_we_q     <= 1'b0;
         imem_addr_q   <= '0;
         imem_wdata_q  <= '0;
         word_count_q  <= '0;
         cycle_count_q <= '0;
         halted_q      <= 1'b0;
         overflow_q    <= 1'b0;
         rel_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         cpu_rst_q     <= cpu_rst_d;
         imem_we_q     <= imem_we_d;
         imem_addr_q   <= imem_addr_d;
         imem_wdata_q  <= imem_wdata_d;
         word_count_q  <= word_count_d;
         cycle_count_q <= cycle_count_d;
         halted_q      <= halted_d;
         overflow_q    <= overflow_d;
         rel_cnt_q     <= rel_cnt_d;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: loads, gaps, overflow, full run,
// reload and mid-load reset, each with hand-computed expectations.
module tb_prog_loader;

   localparam int WORD   = 32;
   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [WORD-1:0]   in_data;
   logic              in_last;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WORD-1:0]   imem_wdata;
   logic              cpu_rst;
   logic              terminate_wb;
   logic              reload;
   logic              halted;
   logic              overflow;
   logic [ADDR_W:0]   word_count;
   logic [31:0]       cycle_count;

   int total_checks = 0;
   int bad_checks   = 0;

   prog_loader #(
      .WORD(WORD),
      .DEPTH(DEPTH),
      .ADDR_W(ADDR_W),
      .RELEASE_CYC(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_last(in_last),
      .in_ready(in_ready),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst),
      .terminate_wb(terminate_wb),
      .reload(reload),
      .halted(halted),
      .overflow(overflow),
      .word_count(word_count),
      .cycle_count(cycle_count)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [39:0] observed,
                              input logic [39:0] expected);
      total_checks++;
      if (observed !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of loader inputs, then waits past the next rising edge.
   task automatic applyStimulus(input logic valid, input logic [WORD-1:0] data,
                                input logic last);
      in_valid = valid;
      in_data  = data;
      in_last  = last;
      @(posedge clk);
      #1;
   endtask

   // One clock with rst held, then release.
   task automatic pulseReset();
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_cpu_rst"}, 40'(cpu_rst), 40'd1);
      checkOutput({tag, "_we"}, 40'(imem_we), 40'd0);
      checkOutput({tag, "_addr"}, 40'(imem_addr), 40'd0);
      checkOutput({tag, "_wdata"}, 40'(imem_wdata), 40'd0);
      checkOutput({tag, "_wc"}, 40'(word_count), 40'd0);
      checkOutput({tag, "_cc"}, 40'(cycle_count), 40'd0);
      checkOutput({tag, "_halted"}, 40'(halted), 40'd0);
      checkOutput({tag, "_ovf"}, 40'(overflow), 40'd0);
      checkOutput({tag, "_ready"}, 40'(in_ready), 40'd1);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int edges;
      logic [WORD-1:0] vals [3];
      vals[0] = 32'h1111_1111;
      vals[1] = 32'h2222_2222;
      vals[2] = 32'h3333_3333;

      rst          = 1'b1;
      in_valid     = 1'b0;
      in_data      = '0;
      in_last      = 1'b0;
      terminate_wb = 1'b0;
      reload       = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      rst = 1'b0;
      checkResetState("reset");

      // 3-word load: writes to 0,1,2 on consecutive edges.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, vals[i], i == 2);
         checkOutput($sformatf("load3_we%0d", i), 40'(imem_we), 40'd1);
         checkOutput($sformatf("load3_addr%0d", i), 40'(imem_addr), 40'(i));
         checkOutput($sformatf("load3_data%0d", i), 40'(imem_wdata), 40'(vals[i]));
      end
      checkOutput("load3_wc", 40'(word_count), 40'd3);
      checkOutput("load3_ready_release", 40'(in_ready), 40'd0);
      checkOutput("load3_cpu_rst_e0", 40'(cpu_rst), 40'd1);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("load3_we_e1", 40'(imem_we), 40'd0);
      checkOutput("load3_cpu_rst_e1", 40'(cpu_rst), 40'd1);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("load3_cpu_rst_e2", 40'(cpu_rst), 40'd1);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("load3_cpu_rst_e3", 40'(cpu_rst), 40'd0);
      checkOutput("load3_cc_run0", 40'(cycle_count), 40'd0);

      // Immediate terminate on the first RUN edge, then reload from HALT.
      terminate_wb = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      terminate_wb = 1'b0;
      checkOutput("quick_halted", 40'(halted), 40'd1);
      checkOutput("quick_cc", 40'(cycle_count), 40'd0);
      reload = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      reload = 1'b0;
      checkOutput("reload_halted", 40'(halted), 40'd0);
      checkOutput("reload_cpu_rst", 40'(cpu_rst), 40'd1);
      checkOutput("reload_wc", 40'(word_count), 40'd0);
      checkOutput("reload_addr", 40'(imem_addr), 40'd0);
      checkOutput("reload_ready", 40'(in_ready), 40'd1);

      // Gapped load: valid 1,0,1,0,1.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i % 2 == 0, 32'hA000_0000 + 32'(i), i == 4);
         checkOutput($sformatf("gap_we%0d", i), 40'(imem_we), 40'(i % 2 == 0));
         if (i % 2 == 0)
            checkOutput($sformatf("gap_addr%0d", i), 40'(imem_addr), 40'(i / 2));
      end
      checkOutput("gap_wc", 40'(word_count), 40'd3);
      pulseReset();

      // Mid-load reset after the second beat.
      applyStimulus(1'b1, 32'hDEAD_0001, 1'b0);
      applyStimulus(1'b1, 32'hDEAD_0002, 1'b0);
      checkOutput("mid_addr_pre", 40'(imem_addr), 40'd1);
      pulseReset();
      checkResetState("mid_rst");
      applyStimulus(1'b1, 32'hBEEF_0003, 1'b0);
      checkOutput("mid_addr_next", 40'(imem_addr), 40'd0);
      checkOutput("mid_data_next", 40'(imem_wdata), 40'h00BEEF_0003);
      checkOutput("mid_wc_next", 40'(word_count), 40'd1);
      pulseReset();

      // Overflow: DEPTH words, no last.
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 32'(i), 1'b0);
      checkOutput("ovf_addr", 40'(imem_addr), 40'(DEPTH - 1));
      checkOutput("ovf_flag", 40'(overflow), 40'd1);
      checkOutput("ovf_wc", 40'(word_count), 40'(DEPTH));
      checkOutput("ovf_ready", 40'(in_ready), 40'd0);
      checkOutput("ovf_cpu_rst", 40'(cpu_rst), 40'd1);
      terminate_wb = 1'b1;
      applyStimulus(1'b1, 32'h5555_5555, 1'b0);
      terminate_wb = 1'b0;
      checkOutput("ovf_extra_we", 40'(imem_we), 40'd0);
      checkOutput("ovf_extra_wc", 40'(word_count), 40'(DEPTH));
      checkOutput("ovf_extra_cpu_rst", 40'(cpu_rst), 40'd1);
      checkOutput("ovf_extra_halted", 40'(halted), 40'd0);
      reload = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      reload = 1'b0;
      checkOutput("ovf_reload_flag", 40'(overflow), 40'd0);
      checkOutput("ovf_reload_wc", 40'(word_count), 40'd0);
      checkOutput("ovf_reload_ready", 40'(in_ready), 40'd1);

      // Full load of exactly DEPTH words with last on the final one.
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 32'hC000_0000 + 32'(i), i == DEPTH - 1);
      checkOutput("full_addr", 40'(imem_addr), 40'(DEPTH - 1));
      checkOutput("full_ovf", 40'(overflow), 40'd0);
      checkOutput("full_wc", 40'(word_count), 40'(DEPTH));
      edges = 0;
      while (cpu_rst && edges < 8) begin
         applyStimulus(1'b0, '0, 1'b0);
         edges++;
      end
      checkOutput("full_release_edges", 40'(edges), 40'd3);

      // Nine RUN edges without terminate, terminate on the tenth.
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b0, '0, 1'b0);
      checkOutput("run_cc9", 40'(cycle_count), 40'd9);
      terminate_wb = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("run_halted", 40'(halted), 40'd1);
      checkOutput("run_cc_at_halt", 40'(cycle_count), 40'd9);
      terminate_wb = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      terminate_wb = 1'b1;
      applyStimulus(1'b1, 32'h7777_7777, 1'b0);
      terminate_wb = 1'b0;
      checkOutput("halt_cc_frozen", 40'(cycle_count), 40'd9);
      checkOutput("halt_wc_frozen", 40'(word_count), 40'(DEPTH));
      checkOutput("halt_cpu_rst", 40'(cpu_rst), 40'd0);
      checkOutput("halt_we", 40'(imem_we), 40'd0);
      checkOutput("halt_still", 40'(halted), 40'd1);

      // Reload from HALT and load a fresh program from address 0.
      reload = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      reload = 1'b0;
      checkOutput("reload2_cc", 40'(cycle_count), 40'd0);
      checkOutput("reload2_cpu_rst", 40'(cpu_rst), 40'd1);
      applyStimulus(1'b1, 32'h0BAD_F00D, 1'b1);
      checkOutput("reload2_addr", 40'(imem_addr), 40'd0);
      checkOutput("reload2_data", 40'(imem_wdata), 40'h000BAD_F00D);
      checkOutput("reload2_wc", 40'(word_count), 40'd1);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
